sound_sequencer: RTL and testbench

Parametrised multi-sound square-wave player for the game audio path. It replaces the single-purpose fixed-table player with these features:
- NUM_SOUNDS selectable sounds.
- Fixed-priority arbitration with pre-emption.
- Per-sound one-shot or repeat mode.
- An external pitch-period ROM port.

It sits between the game-event logic (trigger pulses) and the 1-bit speaker pin.

---
 rtl/sound_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_sound_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - multi-sound square-wave player with priority pre-emption
//
// Plays one of NUM_SOUNDS pitch-period tables from an external ROM as a
// square wave on a single speaker pin. A lower sound index has higher
// priority. An accepted trigger pre-empts or restarts the current sound.
// Optional portamento is enabled by defining GLIDE_EN.
//
// Ports:
//   clk, reset    system clock; synchronous active-high reset
//   trig          one-cycle start pulse per sound
//   loop_en       per sound: 1 = play REPEAT times, 0 = play once
//   len_table     last valid ROM address per sound (slice i = sound i)
//   stop          abort the current sound; no sound_done is produced
//   rom_sel       sound index presented to the ROM
//   rom_addr      word address presented to the ROM
//   rom_data      period word, valid one cycle after rom_sel/rom_addr change
//   speaker       square-wave output
//   busy          a sound is loading or playing
//   active_id     sound currently loading or playing
//   sound_start   one-cycle pulse when a trigger is accepted
//   sound_done    one-cycle pulse when a sound completes naturally
module sound_sequencer #(
  parameter int CLK_DIV    = 4535,
  parameter int NUM_SOUNDS = 8,
  parameter int ADDR_W     = 12,
  parameter int PERIOD_W   = 12,
  parameter int REPEAT     = 4,
  parameter int MIN_P      = 11,
  parameter int MAX_P      = 510
`ifdef GLIDE_EN
  , parameter int GLIDE_SHIFT = 3
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SOUNDS-1:0]          trig,
  input  logic [NUM_SOUNDS-1:0]          loop_en,
  input  logic [NUM_SOUNDS*ADDR_W-1:0]   len_table,
  input  logic                           stop,
  output logic [$clog2(NUM_SOUNDS)-1:0]  rom_sel,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [PERIOD_W-1:0]            rom_data,
  output logic                           speaker,
  output logic                           busy,
  output logic [$clog2(NUM_SOUNDS)-1:0]  active_id,
  output logic                           sound_start,
  output logic                           sound_done
);

  localparam int ID_W = $clog2(NUM_SOUNDS);
  localparam int TW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW   = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t              state, state_next;
  logic [TW-1:0]       tick_cnt;
  logic [PERIOD_W-1:0] half_cnt;
  logic [LW-1:0]       loop_cnt;
  logic [PERIOD_W-1:0] p;
  logic [ADDR_W-1:0]   cur_len;
  logic [ID_W-1:0]     winner;
  logic tick, accept, play_tick, word_end, in_window, at_end, can_loop, finish;

  assign tick      = (tick_cnt == TW'(CLK_DIV - 1));
  assign cur_len   = len_table[active_id*ADDR_W +: ADDR_W];
  assign busy      = (state != IDLE);
  assign rom_sel   = active_id;

`ifdef GLIDE_EN
  // eff_p slews one step toward rom_data each time the chosen tick_cnt bit
  // changes, giving a portamento between consecutive notes.
  logic [PERIOD_W-1:0] eff_p;
  logic                glide_prev;
  logic [31:0]         tick_ext;
  logic                glide_step;

  assign tick_ext   = 32'(tick_cnt);
  assign glide_step = (tick_ext[GLIDE_SHIFT] != glide_prev);
  assign p          = eff_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      eff_p      <= '0;
      glide_prev <= 1'b0;
    end else begin
      glide_prev <= tick_ext[GLIDE_SHIFT];
      if (state == LOAD)
        eff_p <= rom_data;
      else if (glide_step && eff_p < rom_data)
        eff_p <= eff_p + 1'b1;
      else if (glide_step && eff_p > rom_data)
        eff_p <= eff_p - 1'b1;
    end
  end
`else
  assign p = rom_data;
`endif

  // Lowest set trigger index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_SOUNDS - 1; i >= 0; i--)
      if (trig[i]) winner = ID_W'(i);
  end

  always_comb begin
    accept     = (|trig) && (state == IDLE || winner <= active_id);
    play_tick  = (state == PLAY) && tick;
    word_end   = play_tick && !(half_cnt < p);
    in_window  = (p >= PERIOD_W'(MIN_P)) && (p <= PERIOD_W'(MAX_P));
    at_end     = !(rom_addr < cur_len);
    can_loop   = loop_en[active_id] && (loop_cnt < LW'(REPEAT - 1));
    finish     = word_end && at_end && !can_loop;
    state_next = state;
    if (stop)
      state_next = IDLE;
    else if (accept)
      state_next = LOAD;
    else begin
      case (state)
        LOAD:    state_next = PLAY;
        PLAY:    if (finish) state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      active_id   <= '0;
      rom_addr    <= '0;
      half_cnt    <= '0;
      loop_cnt    <= '0;
      speaker     <= 1'b0;
      sound_start <= 1'b0;
      sound_done  <= 1'b0;
    end else begin
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      sound_start <= 1'b0;
      sound_done  <= 1'b0;
      if (stop) begin
        speaker <= 1'b0;
      end else if (accept) begin
        active_id   <= winner;
        rom_addr    <= '0;
        half_cnt    <= '0;
        loop_cnt    <= '0;
        speaker     <= 1'b0;
        sound_start <= 1'b1;
        // A sound finishing on the same cycle still reports completion.
        sound_done  <= finish;
      end else if (play_tick) begin
        if (!word_end) begin
          half_cnt <= half_cnt + 1'b1;
        end else begin
          half_cnt <= '0;
          if (finish) begin
            speaker    <= 1'b0;
            sound_done <= 1'b1;
          end else begin
            if (in_window) speaker <= ~speaker;
            if (!at_end) begin
              rom_addr <= rom_addr + 1'b1;
            end else begin
              rom_addr <= '0;
              loop_cnt <= loop_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - self-checking bench for sound_sequencer
module tb_sound_sequencer;

  localparam int CLK_DIV = 4;
  localparam int NS      = 4;
  localparam int AW      = 4;
  localparam int PW      = 8;
  localparam int REPEAT  = 2;
  localparam int MIN_P   = 2;
  localparam int MAX_P   = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] trig = '0;
  logic [NS-1:0] loop_en = '0;
  logic          stop = 1'b0;
  logic [NS*AW-1:0] len_table;
  logic [1:0]    rom_sel;
  logic [AW-1:0] rom_addr;
  logic [PW-1:0] rom_data = '0;
  logic          speaker, busy, sound_start, sound_done;
  logic [1:0]    active_id;

  logic [AW-1:0] len_v [NS];
  logic [PW-1:0] rom [NS][16];

  int vectors = 0;
  int errors  = 0;

  // Reference model: plain bookkeeping of what is playing and for how long.
  int m_tc, m_id, m_addr, m_elapsed, m_plays;
  bit m_play, m_load, m_spk, m_start, m_done;

  assign len_table = {len_v[3], len_v[2], len_v[1], len_v[0]};

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_sel][rom_addr];

  sound_sequencer #(
    .CLK_DIV(CLK_DIV), .NUM_SOUNDS(NS), .ADDR_W(AW), .PERIOD_W(PW),
    .REPEAT(REPEAT), .MIN_P(MIN_P), .MAX_P(MAX_P)
  ) dut (
    .clk(clk), .reset(reset), .trig(trig), .loop_en(loop_en),
    .len_table(len_table), .stop(stop), .rom_sel(rom_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .speaker(speaker),
    .busy(busy), .active_id(active_id), .sound_start(sound_start),
    .sound_done(sound_done)
  );

  task automatic model_step();
    bit tk, fin, wend, acc;
    int p, w;
    tk = (m_tc == CLK_DIV - 1);
    if (reset) begin
      m_tc = 0; m_id = 0; m_addr = 0; m_elapsed = 0; m_plays = 0;
      m_play = 0; m_load = 0; m_spk = 0; m_start = 0; m_done = 0;
      return;
    end
    m_tc = tk ? 0 : m_tc + 1;
    m_start = 0;
    m_done = 0;
    fin = 0;
    wend = 0;
    p = 0;
    if (m_play && tk) begin
      p = rom[m_id][m_addr];
      wend = (m_elapsed == p);
      if (wend && m_addr >= len_v[m_id] && !(loop_en[m_id] && m_plays < REPEAT - 1))
        fin = 1;
    end
    w = -1;
    for (int i = NS - 1; i >= 0; i--) if (trig[i]) w = i;
    acc = (w >= 0) && (!(m_play || m_load) || w <= m_id);
    if (stop) begin
      m_play = 0; m_load = 0; m_spk = 0;
    end else if (acc) begin
      m_done = fin; m_id = w; m_addr = 0; m_elapsed = 0; m_plays = 0;
      m_spk = 0; m_start = 1; m_load = 1; m_play = 0;
    end else if (m_load) begin
      m_load = 0; m_play = 1;
    end else if (m_play && tk) begin
      if (!wend) m_elapsed++;
      else begin
        m_elapsed = 0;
        if (fin) begin
          m_done = 1; m_spk = 0; m_play = 0;
        end else begin
          if (p >= MIN_P && p <= MAX_P) m_spk = !m_spk;
          if (m_addr < len_v[m_id]) m_addr++;
          else begin m_addr = 0; m_plays++; end
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    bit m_busy;
    m_busy = m_play || m_load;
    vectors++;
    if (speaker !== m_spk || busy !== m_busy || active_id !== 2'(m_id) ||
        rom_sel !== 2'(m_id) || rom_addr !== AW'(m_addr) ||
        sound_start !== m_start || sound_done !== m_done) begin
      errors++;
      $display("FAIL %s t=%0t: got spk=%0b busy=%0b id=%0d sel=%0d addr=%0d start=%0b done=%0b, expected spk=%0b busy=%0b id=%0d sel=%0d addr=%0d start=%0b done=%0b",
               name, $time, speaker, busy, active_id, rom_sel, rom_addr, sound_start,
               sound_done, m_spk, m_busy, m_id, m_id, m_addr, m_start, m_done);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Runs until sound_done or the cycle budget expires; checks every cycle.
  task automatic run_sound(input string name, input int budget, output int trans,
                           output int wraps, output int done_seen, output int max_addr);
    logic          prev_spk;
    logic [AW-1:0] prev_addr;
    trans = 0; wraps = 0; done_seen = 0; max_addr = 0;
    for (int c = 0; c < budget && done_seen == 0; c++) begin
      prev_spk = speaker;
      prev_addr = rom_addr;
      step();
      check_model(name);
      if (speaker !== prev_spk) trans++;
      if (busy && rom_addr < prev_addr) wraps++;
      if (int'(rom_addr) > max_addr) max_addr = rom_addr;
      if (sound_done) done_seen = 1;
    end
  endtask

  task automatic pulse(input logic [NS-1:0] t, input string name);
    trig = t;
    step();
    check_model(name);
    trig = '0;
  endtask

  typedef struct {
    bit       rst;
    bit [3:0] trig;
    bit       stop;
    bit       busy;
    bit [1:0] id;
    bit       start;
    bit       done;
    bit       spk;
    bit [3:0] addr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int trans, wraps, done_seen, max_addr;

    for (int s = 0; s < NS; s++) begin
      len_v[s] = 4'd3;
      for (int a = 0; a < 16; a++) rom[s][a] = 8'd10;
    end

    //          rst trig    stop busy id   st done spk addr
    tbl[0]  = '{1, 4'b0000, 0,   0,   2'd0, 0, 0,  0,  4'd0};
    tbl[1]  = '{0, 4'b0000, 0,   0,   2'd0, 0, 0,  0,  4'd0};
    tbl[2]  = '{0, 4'b1010, 0,   1,   2'd1, 1, 0,  0,  4'd0};
    tbl[3]  = '{0, 4'b0000, 0,   1,   2'd1, 0, 0,  0,  4'd0};
    tbl[4]  = '{0, 4'b1000, 0,   1,   2'd1, 0, 0,  0,  4'd0};
    tbl[5]  = '{0, 4'b0001, 0,   1,   2'd0, 1, 0,  0,  4'd0};
    tbl[6]  = '{0, 4'b1000, 0,   1,   2'd0, 0, 0,  0,  4'd0};
    tbl[7]  = '{0, 4'b0001, 0,   1,   2'd0, 1, 0,  0,  4'd0};
    tbl[8]  = '{0, 4'b0001, 1,   0,   2'd0, 0, 0,  0,  4'd0};
    tbl[9]  = '{0, 4'b0000, 0,   0,   2'd0, 0, 0,  0,  4'd0};
    tbl[10] = '{0, 4'b0100, 0,   1,   2'd2, 1, 0,  0,  4'd0};
    tbl[11] = '{0, 4'b0000, 0,   1,   2'd2, 0, 0,  0,  4'd0};
    tbl[12] = '{1, 4'b0000, 0,   0,   2'd0, 0, 0,  0,  4'd0};
    tbl[13] = '{0, 4'b0000, 0,   0,   2'd0, 0, 0,  0,  4'd0};

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst;
      trig  = tbl[i].trig;
      stop  = tbl[i].stop;
      step();
      vectors++;
      if (busy !== tbl[i].busy || active_id !== tbl[i].id || rom_sel !== tbl[i].id ||
          sound_start !== tbl[i].start || sound_done !== tbl[i].done ||
          speaker !== tbl[i].spk || rom_addr !== tbl[i].addr) begin
        errors++;
        $display("FAIL table[%0d]: got busy=%0b id=%0d sel=%0d start=%0b done=%0b spk=%0b addr=%0d, expected busy=%0b id=%0d start=%0b done=%0b spk=%0b addr=%0d",
                 i, busy, active_id, rom_sel, sound_start, sound_done, speaker, rom_addr,
                 tbl[i].busy, tbl[i].id, tbl[i].start, tbl[i].done, tbl[i].spk, tbl[i].addr);
      end
    end
    reset = 0; trig = '0; stop = 0;

    // One-shot: words {4,4,0,4}. Words 0,1,3 toggle, but completion forces
    // the speaker low on the last word, so only two transitions are seen.
    rom[1][0] = 8'd4; rom[1][1] = 8'd4; rom[1][2] = 8'd0; rom[1][3] = 8'd4;
    len_v[1] = 4'd3;
    loop_en = 4'b0000;
    pulse(4'b0010, "oneshot_start");
    run_sound("oneshot", 200, trans, wraps, done_seen, max_addr);
    check_val("oneshot_done", done_seen, 1);
    check_val("oneshot_trans", trans, 2);
    check_val("oneshot_wraps", wraps, 0);
    step(); check_model("oneshot_idle");
    check_val("oneshot_busy_after", int'(busy), 0);

    // Loop: the table plays twice; final completion drops the speaker.
    loop_en = 4'b0010;
    pulse(4'b0010, "loop_start");
    run_sound("loop", 400, trans, wraps, done_seen, max_addr);
    check_val("loop_done", done_seen, 1);
    check_val("loop_trans", trans, 6);
    check_val("loop_wraps", wraps, 1);
    step(); check_model("loop_idle");
    check_val("loop_busy_after", int'(busy), 0);
    loop_en = 4'b0000;

    // Out-of-window periods stay silent while addresses still advance.
    rom[2][0] = 8'd1; rom[2][1] = 8'd25;
    len_v[2] = 4'd1;
    pulse(4'b0100, "window_start");
    run_sound("window", 200, trans, wraps, done_seen, max_addr);
    check_val("window_done", done_seen, 1);
    check_val("window_trans", trans, 0);
    check_val("window_addr", max_addr, 1);

    // Reset in the middle of playback.
    pulse(4'b0010, "rstmid_start");
    for (int c = 0; c < 40; c++) begin step(); check_model("rstmid_play"); end
    check_val("rstmid_was_busy", int'(busy), 1);
    reset = 1;
    step();
    check_val("rstmid_outputs",
              int'({speaker, busy, sound_start, sound_done, rom_addr, rom_sel, active_id}), 0);
    reset = 0;
    step(); check_model("rstmid_after");

    // Randomised traffic against the reference model.
    for (int s = 0; s < NS; s++) begin
      len_v[s] = AW'($urandom_range(0, 3));
      for (int a = 0; a < 4; a++) rom[s][a] = PW'($urandom_range(0, 24));
    end
    for (int c = 0; c < 4000; c++) begin
      trig  = ($urandom_range(0, 39) == 0) ? NS'($urandom_range(1, 15)) : '0;
      stop  = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 99) == 0) loop_en = NS'($urandom_range(0, 15));
      step();
      check_model("random");
    end
    trig = '0; stop = 0; reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
